ahf_risc521_brd_rdy: RTL and testbench
======================================

// Module: ahf_risc521_brd_rdy
// PURPOSE
//   Board-level top of the RISC521 teaching core: a tiny 8-bit multicycle CPU
//   with a fixed 16-word instruction ROM, a 5-bit switch input port and an
//   8-bit display output port. Runs its built-in program continuously after reset.
// PARAMETERS
//   DATA_W       8   datapath / register / DISP width
//   SYNC_STAGES  2   flip-flop stages on SW before the CPU samples it
//   ROM_DEPTH   16   instruction words (PC width = 4)
// PORTS
//   CLOCK_50  in   1  system clock; all state updates on rising edge
//   Reset     in   1  synchronous, active-high reset
//   SW        in   5  switch input port (asynchronous to core)
//   DISP      out  8  display output register
// BEHAVIOUR
//   Clocking: one clock; reset is synchronous and active-high.
//   Reset, sampled at a rising edge, zeroes PC, R0-R3, Z flag, IR, sync
//     flops and DISP, and sets state FETCH. Applies mid-instruction too.
//   State machine, 3 clocks per instruction, no stalls:
//     FETCH -> DECODE -> EXECUTE -> FETCH.
//     FETCH: IR <= ROM[PC]. DECODE: read operands.
//     EXECUTE: write-back/flags/DISP, then PC update.
//   PC update: PC <= PC+1 (4-bit, 15 wraps to 0) unless a jump is taken.
//   Instruction word, 12 bits:
//     op[11:8], rd[7:6], rs[5:4], imm6[5:0], target = imm[3:0].
//   Opcodes:
//     0 NOP; 1 LDI rd<=zext(imm6); 2 MOV rd<=rs;
//     3 ADD rd<=rd+rs; 4 SUB rd<=rd-rs; 5 AND; 6 OR; 7 XOR;
//     8 NOT rd<=~rd; 9 SHL rd<=rd<<1;
//     A IN rd<={3'b0,SW_sync}; B OUT DISP<=rd;
//     C JMP PC<=target; D JZ: if Z then PC<=target else PC+1;
//     E,F NOP.
//   Arithmetic: modulo 2^8, no carry flag.
//   Z flag: updated only by ops 3-9, set when the 8-bit result is 0.
//   DISP: registered; changes only in EXECUTE of OUT; holds value otherwise.
//   SW: passes SYNC_STAGES flops; IN reads the last stage.
//   ROM contents (fixed; unused words = 000 NOP):
//     0: A00  IN  R0
//     1: 143  LDI R1,3
//     2: 310  ADD R0,R1
//     3: B00  OUT R0
//     4: C00  JMP 0
//   Net function: DISP = (SW + 3) mod 256, 15-clock loop.
//   DISP latency: reflects a stable SW change within 40 clocks.
//   NOP region (PC 5-15) is reachable only by a ROM edit; PC wraps normally.
// TESTING
//   1. Reset high 15 clocks, SW=00000 -> DISP=0x00 throughout; first OUT
//      (EXECUTE of PC=3, clock 12 after release) -> DISP=0x03.
//   2. SW=11010 (26) held 80 clocks -> DISP=0x1D within 40 clocks, stable after.
//   3. SW toggles 11010 -> 01010 -> 11110, 80 clocks each ->
//      DISP 0x1D -> 0x0D -> 0x21.
//   4. SW=11111 -> DISP=0x22; loop period is exactly 15 clocks (OUT every 15th edge).
//   5. Reset asserted mid-loop for 1 clock -> DISP=0x00 next edge; restarts at PC=0.
//   6. Long run 40000 clocks, SW=00000 -> DISP stays 0x03; no X on DISP.

Source files
------------

// File: rtl/ahf_risc521_brd_rdy.sv
// RISC521 board top: 8-bit multicycle teaching CPU with a fixed 16-word ROM,
// a synchronised 5-bit switch input and a registered 8-bit display output.
module ahf_risc521_brd_rdy #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ROM_DEPTH   = 16
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [4:0]        SW,
  output logic [DATA_W-1:0] DISP
);

  localparam int PC_W = $clog2(ROM_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_NOT = 4'h8, OP_SHL = 4'h9, OP_IN  = 4'hA, OP_OUT = 4'hB,
    OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_NPE = 4'hE, OP_NPF = 4'hF
  } op_t;

  function automatic logic [11:0] rom_word(input logic [PC_W-1:0] addr);
    case (addr)
      PC_W'(0): rom_word = 12'hA00;  // IN  R0
      PC_W'(1): rom_word = 12'h143;  // LDI R1,3
      PC_W'(2): rom_word = 12'h310;  // ADD R0,R1
      PC_W'(3): rom_word = 12'hB00;  // OUT R0
      PC_W'(4): rom_word = 12'hC00;  // JMP 0
      default:  rom_word = 12'h000;
    endcase
  endfunction

  state_t            r_state, w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [11:0]       r_ir;
  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] r_opa, r_opb;
  logic              r_z;
  logic [DATA_W-1:0] r_disp;
  logic [4:0]        r_sw_sync [SYNC_STAGES];

  op_t               w_op;
  logic [1:0]        w_rd, w_rs;
  logic [5:0]        w_imm;
  logic [PC_W-1:0]   w_target;
  logic [DATA_W-1:0] w_result;
  logic              w_ir_load, w_opnd_load, w_wr_en, w_z_en, w_disp_en, w_pc_en, w_jump;

  assign w_op     = op_t'(r_ir[11:8]);
  assign w_rd     = r_ir[7:6];
  assign w_rs     = r_ir[5:4];
  assign w_imm    = r_ir[5:0];
  assign w_target = r_ir[PC_W-1:0];
  assign DISP     = r_disp;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXECUTE;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_ir_load   = 1'b0;
    w_opnd_load = 1'b0;
    w_pc_en     = 1'b0;
    w_wr_en     = 1'b0;
    w_z_en      = 1'b0;
    w_disp_en   = 1'b0;
    w_jump      = 1'b0;
    w_result    = '0;
    case (r_state)
      S_FETCH:  w_ir_load   = 1'b1;
      S_DECODE: w_opnd_load = 1'b1;
      S_EXECUTE: begin
        w_pc_en = 1'b1;
        case (w_op)
          OP_LDI: begin w_result = {{(DATA_W-6){1'b0}}, w_imm}; w_wr_en = 1'b1; end
          OP_MOV: begin w_result = r_opb;           w_wr_en = 1'b1; end
          OP_ADD: begin w_result = r_opa + r_opb;   w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_SUB: begin w_result = r_opa - r_opb;   w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_AND: begin w_result = r_opa & r_opb;   w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_OR:  begin w_result = r_opa | r_opb;   w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_XOR: begin w_result = r_opa ^ r_opb;   w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_NOT: begin w_result = ~r_opa;          w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_SHL: begin w_result = r_opa << 1;      w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_IN:  begin
            w_result = {{(DATA_W-5){1'b0}}, r_sw_sync[SYNC_STAGES-1]};
            w_wr_en  = 1'b1;
          end
          OP_OUT: w_disp_en = 1'b1;
          OP_JMP: w_jump    = 1'b1;
          OP_JZ:  w_jump    = r_z;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: the 4-entry register file is plain flops, so it is cleared by reset like any other state.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_regs <= '{default: '0};
      r_opa  <= '0;
      r_opb  <= '0;
      r_z    <= 1'b0;
      r_disp <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sw_sync[i] <= '0;
    end else begin
      r_sw_sync[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) r_sw_sync[i] <= r_sw_sync[i-1];
      if (w_ir_load) r_ir <= rom_word(r_pc);
      if (w_opnd_load) begin
        r_opa <= r_regs[w_rd];
        r_opb <= r_regs[w_rs];
      end
      if (w_wr_en)   r_regs[w_rd] <= w_result;
      if (w_z_en)    r_z <= (w_result == '0);
      if (w_disp_en) r_disp <= r_opa;
      if (w_pc_en)   r_pc <= w_jump ? w_target : r_pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_ahf_risc521_brd_rdy.sv
// Directed bench for the RISC521 board top: reset, SW->DISP mapping, loop timing, long run.
module tb_ahf_risc521_brd_rdy;

  logic       CLOCK_50 = 1'b0;
  logic       Reset    = 1'b1;
  logic [4:0] SW       = 5'd0;
  logic [7:0] DISP;

  int n_vec  = 0;
  int n_miss = 0;

  ahf_risc521_brd_rdy dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .SW       (SW),
    .DISP     (DISP)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_disp(input string tag, input logic [7:0] exp, input int budget);
    int n = 0;
    while (DISP !== exp && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, DISP, exp);
  endtask

  initial begin
    // 1: reset held 15 clocks, then first OUT lands on edge 12 after release
    Reset = 1'b1;
    SW    = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      tick(5);
      check("reset_hold", DISP, 8'h00);
    end
    Reset = 1'b0;
    tick(11);
    check("before_first_out", DISP, 8'h00);
    tick(1);
    check("first_out", DISP, 8'h03);

    // 2: SW=26 -> 0x1D within 40 clocks, stable afterwards
    SW = 5'b11010;
    wait_disp("sw26_latency", 8'h1D, 40);
    tick(40);
    check("sw26_stable", DISP, 8'h1D);

    // 3: toggle sequence
    SW = 5'b01010;
    wait_disp("sw10_latency", 8'h0D, 40);
    tick(40);
    check("sw10_stable", DISP, 8'h0D);
    SW = 5'b11110;
    wait_disp("sw30_latency", 8'h21, 40);
    tick(40);
    check("sw30_stable", DISP, 8'h21);

    // 4: SW=31 from reset; a change after the first OUT shows up exactly 15 edges later
    SW    = 5'b11111;
    Reset = 1'b1;
    tick(1);
    check("reset_clears_disp", DISP, 8'h00);
    Reset = 1'b0;
    tick(11);
    check("sw31_before_out", DISP, 8'h00);
    tick(1);
    check("sw31_out", DISP, 8'h22);
    SW = 5'b00101;
    tick(14);
    check("period_edge14", DISP, 8'h22);
    tick(1);
    check("period_edge15", DISP, 8'h08);

    // 5: one-clock reset mid-loop, then clean restart from PC=0
    tick(7);
    Reset = 1'b1;
    tick(1);
    check("midloop_reset", DISP, 8'h00);
    Reset = 1'b0;
    tick(11);
    check("restart_before_out", DISP, 8'h00);
    tick(1);
    check("restart_out", DISP, 8'h08);

    // 6: long run with SW=0
    SW = 5'b00000;
    tick(40);
    for (int i = 0; i < 1000; i++) begin
      tick(40);
      check("long_no_x", {7'd0, $isunknown(DISP)}, 8'h00);
      check("long_value", DISP, 8'h03);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
